// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and state encoding for the sequential divider
package div_pkg;

    localparam int DW_DEF = 16;
    localparam int VW_DEF = 8;
    localparam int CNT_W  = $clog2(DW_DEF);

    localparam logic [DW_DEF-1:0] QUOT_ONES = {DW_DEF{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int VW = 8
) (
    input  logic [VW:0]   part_i,
    input  logic [VW-1:0] divisor_i,
    input  logic          dbit_i,
    output logic [VW:0]   part_o,
    output logic          qbit_o
);

    logic [VW+1:0] shifted;
    logic [VW+1:0] trial;

    // Partial remainder is always below the divisor, so the shifted value
    // fits in VW+1 bits and the extra top bit of trial acts as the borrow.
    always_comb begin
        shifted = {part_i, dbit_i};
        trial   = shifted - {2'b00, divisor_i};
        qbit_o  = ~trial[VW+1];
        part_o  = (VW+1)'(qbit_o ? trial : shifted);
    end

endmodule

// File: rtl/seq_divider_16x8.sv
// rtl/seq_divider_16x8.sv - radix-2 restoring divider, one quotient bit per clock
module seq_divider_16x8
    import div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    state_e           state_q, state_d;
    logic [DW-1:0]    dvd_q, dvd_d;
    logic [VW-1:0]    dsr_q, dsr_d;
    logic [VW:0]      part_q, part_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    quot_q, quot_d;
    logic [VW-1:0]    rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [VW:0]      step_part;
    logic             step_qbit;
    logic             accept;
    logic             last_iter;

    div_step #(.VW(VW)) u_step (
        .part_i    (part_q),
        .divisor_i (dsr_q),
        .dbit_i    (dvd_q[DW-1]),
        .part_o    (step_part),
        .qbit_o    (step_qbit)
    );

    assign accept    = in_valid & in_ready;
    assign last_iter = (state_q == CALC) && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = (divisor == '0) ? DONE : CALC;
            CALC: if (cnt_q == '0) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // The dividend register doubles as the quotient shifter: dividend bits
    // leave at the top while quotient bits enter at the bottom.
    always_comb begin
        dvd_d  = dvd_q;
        dsr_d  = dsr_q;
        part_d = part_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        if (state_q == IDLE && accept) begin
            dvd_d  = dividend;
            dsr_d  = divisor;
            part_d = '0;
            if (divisor == '0) begin
                cnt_d  = '0;
                quot_d = QUOT_ONES;
                rem_d  = dividend[VW-1:0];
                dbz_d  = 1'b1;
            end else begin
                cnt_d  = CNT_W'(DW - 1);
                dbz_d  = 1'b0;
            end
        end else if (state_q == CALC) begin
            part_d = step_part;
            dvd_d  = {dvd_q[DW-2:0], step_qbit};
            cnt_d  = cnt_q - 1'b1;
            if (last_iter) begin
                quot_d = {dvd_q[DW-2:0], step_qbit};
                rem_d  = step_part[VW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q  <= '0;
            dsr_q  <= '0;
            part_q <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dbz_q  <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            dsr_q  <= dsr_d;
            part_q <= part_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
